pc_gen: RTL and testbench

Parametrised program-counter generator for the instruction-fetch stage. It replaces the fixed 32-bit, always-incrementing PC register. It adds a configurable reset vector, increment and alignment, plus pipeline stall and branch redirect with a highest-priority flush redirect. It also drives a req/ack handshake toward instruction memory that holds the address stable while a request is outstanding.

---
 rtl/pc_gen.sv | 106 ++++++++++
 tb/tb_pc_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: reset vector, sequential
// increment, stall, branch/flush redirect and a req/ack handshake toward imem.
module pc_gen #(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        INC          = 4,
  parameter int unsigned        ALIGN_BITS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              ack_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              req_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    WAIT_R
  } state_t;

  localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] pend_q, pend_n;
  logic              ce_n;
  logic              fire;

  // An issued request stays up until acked, even if the pipeline stalls.
  always_comb begin
    req_o = 1'b0;
    case (state)
      RUN:         req_o = !stall_i;
      WAIT, WAIT_R: req_o = 1'b1;
      default:     req_o = 1'b0;
    endcase
  end

  assign fire = req_o & ack_i;

  always_comb begin
    state_n = state;
    pc_n    = pc_o;
    pend_n  = pend_q;
    ce_n    = ce_o;
    case (state)
      IDLE: begin
        state_n = RUN;
        ce_n    = 1'b1;
      end
      default: begin
        if (flush_i) begin
          pc_n    = flush_pc_i & ALIGN_MASK;
          pend_n  = '0;
          state_n = RUN;
        end else if (fire) begin
          if (branch_i)
            pc_n = branch_pc_i & ALIGN_MASK;
          else if (state == WAIT_R)
            pc_n = pend_q;
          else
            pc_n = pc_o + INC_V;
          pend_n  = '0;
          state_n = RUN;
        end else if (branch_i) begin
          // With a request outstanding the address must stay put, so park the target.
          if (req_o) begin
            pend_n  = branch_pc_i & ALIGN_MASK;
            state_n = WAIT_R;
          end else begin
            pc_n    = branch_pc_i & ALIGN_MASK;
            state_n = RUN;
          end
        end else if (req_o) begin
          state_n = (state == WAIT_R) ? WAIT_R : WAIT;
        end else begin
          state_n = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc_o   <= RESET_VECTOR;
      ce_o   <= 1'b0;
      pend_q <= '0;
    end else begin
      state  <= state_n;
      pc_o   <= pc_n;
      ce_o   <= ce_n;
      pend_q <= pend_n;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: three instances (defaults, wrapping reset vector, 16-bit)
// share one directed stimulus and are compared each cycle against a flag-based model.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [31:0] branch_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ack;

  logic [31:0] pc_a, pc_b;
  logic [15:0] pc_c;
  logic        ce_a, ce_b, ce_c;
  logic        req_a, req_b, req_c;

  logic [31:0] dut_pc  [3];
  logic        dut_ce  [3];
  logic        dut_req [3];

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  typedef struct {
    logic [31:0] pc;
    bit          en;
    bit          outstanding;
    bit          pend_valid;
    logic [31:0] pend_pc;
  } model_t;

  model_t      mdl [3];
  logic [31:0] rv_tab    [3] = '{32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_0000};
  logic [31:0] wmask_tab [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  int          inc_tab   [3] = '{4, 4, 2};
  int          align_tab [3] = '{2, 2, 1};

  pc_gen u_dut_a (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_i(branch), .branch_pc_i(branch_pc),
    .flush_i(flush), .flush_pc_i(flush_pc), .ack_i(ack),
    .pc_o(pc_a), .ce_o(ce_a), .req_o(req_a)
  );

  pc_gen #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut_b (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_i(branch), .branch_pc_i(branch_pc),
    .flush_i(flush), .flush_pc_i(flush_pc), .ack_i(ack),
    .pc_o(pc_b), .ce_o(ce_b), .req_o(req_b)
  );

  pc_gen #(.ADDR_W(16), .RESET_VECTOR(16'h0000), .INC(2), .ALIGN_BITS(1)) u_dut_c (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_i(branch), .branch_pc_i(branch_pc[15:0]),
    .flush_i(flush), .flush_pc_i(flush_pc[15:0]), .ack_i(ack),
    .pc_o(pc_c), .ce_o(ce_c), .req_o(req_c)
  );

  assign dut_pc[0]  = pc_a;
  assign dut_pc[1]  = pc_b;
  assign dut_pc[2]  = {16'h0000, pc_c};
  assign dut_ce[0]  = ce_a;
  assign dut_ce[1]  = ce_b;
  assign dut_ce[2]  = ce_c;
  assign dut_req[0] = req_a;
  assign dut_req[1] = req_b;
  assign dut_req[2] = req_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_req(input model_t m);
    return m.en && (m.outstanding || !stall);
  endfunction

  // One fetch-unit cycle: reset, enable, then flush > fire > branch > hold.
  function automatic model_t next_model(input model_t m, input int i);
    model_t      n;
    logic [31:0] amask;
    logic        req;
    n     = m;
    amask = wmask_tab[i] & ~((32'd1 << align_tab[i]) - 32'd1);
    req   = model_req(m);
    if (rst) begin
      n.pc = rv_tab[i]; n.en = 0; n.outstanding = 0; n.pend_valid = 0;
    end else if (!m.en) begin
      n.en = 1;
    end else if (flush) begin
      n.pc = flush_pc & amask; n.outstanding = 0; n.pend_valid = 0;
    end else if (req && ack) begin
      if (branch)           n.pc = branch_pc & amask;
      else if (m.pend_valid) n.pc = m.pend_pc;
      else                  n.pc = (m.pc + 32'(inc_tab[i])) & wmask_tab[i];
      n.outstanding = 0; n.pend_valid = 0;
    end else if (branch && !req) begin
      n.pc = branch_pc & amask;
    end else if (branch) begin
      n.pend_pc = branch_pc & amask; n.pend_valid = 1; n.outstanding = 1;
    end else begin
      n.outstanding = req;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) mdl[i] <= next_model(mdl[i], i);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("pc[%0d]", i),  dut_pc[i], mdl[i].pc);
        checkOutput($sformatf("ce[%0d]", i),  32'(dut_ce[i]), 32'(mdl[i].en));
        checkOutput($sformatf("req[%0d]", i), 32'(dut_req[i]), 32'(model_req(mdl[i])));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [31:0] bpc,
                               input logic f, input logic [31:0] fpc, input logic a);
    rst = r; stall = s; branch = b; branch_pc = bpc; flush = f; flush_pc = fpc; ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; branch = 0; branch_pc = 0; flush = 0; flush_pc = 0; ack = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_pc_a", pc_a, 32'h0);
    checkOutput("rst_ce_a", 32'(ce_a), 32'd0);
    checkOutput("rst_req_a", 32'(req_a), 32'd0);
    checkOutput("rst_pc_b", pc_b, 32'hFFFF_FFF8);
    checking = 1;

    // Release: enable, then sequential fetch with ack held high
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("en_ce_a", 32'(ce_a), 32'd1);
    checkOutput("en_pc_a", pc_a, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("seq1_a", pc_a, 32'h4);
    checkOutput("seq1_b", pc_b, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("seq2_a", pc_a, 32'h8);
    checkOutput("wrap_b", pc_b, 32'h0);

    // Stall with nothing outstanding
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 1);
      checkOutput("stall_hold_a", pc_a, 32'h8);
    end
    checkOutput("stall_req_a", 32'(req_a), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("resume_a", pc_a, 32'hC);
    checkOutput("resume_b", pc_b, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("seq_10_a", pc_a, 32'h10);

    // Delayed ack with a branch arriving mid-wait
    applyStimulus(0, 0, 0, 0,         0, 0, 0);
    applyStimulus(0, 1, 1, 32'h103,   0, 0, 0);
    applyStimulus(0, 1, 0, 0,         0, 0, 0);
    checkOutput("wait_hold_a", pc_a, 32'h10);
    checkOutput("wait_req_a", 32'(req_a), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("br_taken_a", pc_a, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("br_next_a", pc_a, 32'h104);

    // Flush discards a pending redirect
    applyStimulus(0, 0, 1, 32'h200, 0, 0,             0);
    applyStimulus(0, 0, 0, 0,       1, 32'h8000_0180, 0);
    checkOutput("flush_a", pc_a, 32'h8000_0180);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("flush_next_a", pc_a, 32'h8000_0184);

    // Flush coincident with fire: flush target wins
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0043, 1);
    checkOutput("flush_fire_a", pc_a, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("flush_fire_next_a", pc_a, 32'h44);

    // Branch while stalled applies directly; branch with fire
    applyStimulus(0, 1, 1, 32'h302, 0, 0, 0);
    checkOutput("br_stall_a", pc_a, 32'h300);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h500, 0, 0, 1);
    checkOutput("br_fire_a", pc_a, 32'h500);

    // Newer pending branch overwrites older one
    applyStimulus(0, 0, 1, 32'h600, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h700, 0, 0, 0);
    checkOutput("pend_hold_a", pc_a, 32'h500);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("pend_new_a", pc_a, 32'h700);

    // Odd branch target aligned differently per instance
    applyStimulus(0, 0, 1, 32'h1235, 0, 0, 1);
    checkOutput("align_a", pc_a, 32'h1234);
    checkOutput("align_c", 32'(pc_c), 32'h1234);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("align_next_c", 32'(pc_c), 32'h1236);
    checkOutput("align_next_a", pc_a, 32'h1238);

    // Reset in the middle of an outstanding request
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h900, 1);
    checkOutput("mid_rst_pc_c", 32'(pc_c), 32'h0);
    checkOutput("mid_rst_ce_c", 32'(ce_c), 32'd0);
    checkOutput("mid_rst_pc_b", pc_b, 32'hFFFF_FFF8);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("re_en_ce_a", 32'(ce_a), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("re_seq_c", 32'(pc_c), 32'h2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
